// File: rtl/reloj_pkg.sv
// Shared types and channel indices for the clock's button front end.
package reloj_pkg;

  typedef enum logic [1:0] {
    LOCKOUT = 2'd0,
    IDLE    = 2'd1,
    HELD    = 2'd2,
    REPEAT  = 2'd3
  } estado_boton_t;

  localparam int unsigned BTN_INCR = 0;
  localparam int unsigned BTN_DECR = 1;
  localparam int unsigned BTN_CAMB = 2;
  localparam int unsigned BTN_EST  = 3;

  // Only the step buttons auto-repeat by default.
  localparam logic [3:0] REP_MASK_DEF = 4'((1 << BTN_INCR) | (1 << BTN_DECR));

endpackage

// File: rtl/canal_boton.sv
// One button channel: 2-flop synchroniser, debounce, press/repeat FSM.
module canal_boton
  import reloj_pkg::*;
#(
  parameter int unsigned DEB_CYC   = 20,
  parameter int unsigned REP_DELAY = 1000,
  parameter int unsigned REP_RATE  = 250,
  parameter bit          REP_EN    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n_i,
  output logic pulso_o,
  output logic nivel_o,
  output logic bloqueo_o
);

  // Two extra cycles cover the synchroniser refilling after reset, so a
  // button held through reset cannot look released for DEB_CYC cycles.
  localparam int unsigned LOCK_CYC = DEB_CYC + 2;
  localparam int unsigned REP_MAX0 = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int unsigned REP_MAX  = (REP_MAX0 > LOCK_CYC) ? REP_MAX0 : LOCK_CYC;
  localparam int unsigned DEB_W    = $clog2(DEB_CYC + 1);
  localparam int unsigned REP_W    = $clog2(REP_MAX + 1);

  logic              sync1_q;
  logic              sync2_q;
  logic              pulsado;
  logic              pendiente;
  logic [DEB_W-1:0]  cnt_deb_q;
  logic              nivel_q;
  estado_boton_t     estado_q;
  logic [REP_W-1:0]  cnt_rep_q;
  logic [REP_W-1:0]  objetivo;
  logic              pulso_q;
  logic              bloqueo_q;

  assign pulsado   = ~sync2_q;
  assign pendiente = (pulsado != nivel_q);
  assign objetivo  = (estado_q == HELD) ? REP_W'(REP_DELAY - 1) : REP_W'(REP_RATE - 1);

  // Synchronise the raw pin; reset value means released.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
    end
  end

  // Accept a level change after DEB_CYC consecutive disagreeing cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_deb_q <= '0;
      nivel_q   <= 1'b0;
    end else if (!pendiente) begin
      cnt_deb_q <= '0;
    end else if (cnt_deb_q == DEB_W'(DEB_CYC - 1)) begin
      cnt_deb_q <= '0;
      nivel_q   <= pulsado;
    end else if (cnt_deb_q != DEB_W'(DEB_CYC)) begin
      cnt_deb_q <= cnt_deb_q + DEB_W'(1);
    end
  end

  // Press/repeat FSM; pulses come one cycle after the debounced rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q  <= LOCKOUT;
      cnt_rep_q <= '0;
      pulso_q   <= 1'b0;
      bloqueo_q <= 1'b1;
    end else begin
      pulso_q <= 1'b0;
      case (estado_q)
        LOCKOUT: begin
          if (!pulsado && !nivel_q) begin
            if (cnt_rep_q == REP_W'(LOCK_CYC - 1)) begin
              cnt_rep_q <= '0;
              estado_q  <= IDLE;
              bloqueo_q <= 1'b0;
            end else if (cnt_rep_q != REP_W'(REP_MAX)) begin
              cnt_rep_q <= cnt_rep_q + REP_W'(1);
            end
          end else begin
            cnt_rep_q <= '0;
          end
        end
        IDLE: begin
          if (nivel_q) begin
            pulso_q   <= 1'b1;
            cnt_rep_q <= '0;
            estado_q  <= HELD;
          end
        end
        HELD, REPEAT: begin
          if (!nivel_q) begin
            cnt_rep_q <= '0;
            estado_q  <= IDLE;
          end else if (!pendiente) begin
            if (REP_EN && (cnt_rep_q == objetivo)) begin
              pulso_q   <= 1'b1;
              cnt_rep_q <= '0;
              estado_q  <= REPEAT;
            end else if (cnt_rep_q != REP_W'(REP_MAX)) begin
              cnt_rep_q <= cnt_rep_q + REP_W'(1);
            end
          end
        end
        default: begin
          cnt_rep_q <= '0;
          estado_q  <= LOCKOUT;
          bloqueo_q <= 1'b1;
        end
      endcase
    end
  end

  assign pulso_o   = pulso_q;
  assign nivel_o   = nivel_q;
  assign bloqueo_o = bloqueo_q;

endmodule

// File: rtl/acondicionador_botones.sv
// Conditions the four raw clock buttons into clean press/repeat pulses.
module acondicionador_botones
  import reloj_pkg::*;
#(
  parameter int unsigned      N_BTN     = 4,
  parameter int unsigned      DEB_CYC   = 20,
  parameter int unsigned      REP_DELAY = 1000,
  parameter int unsigned      REP_RATE  = 250,
  parameter logic [N_BTN-1:0] REP_MASK  = N_BTN'(REP_MASK_DEF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_n,
  output logic [N_BTN-1:0] pulso,
  output logic [N_BTN-1:0] nivel,
  output logic             bloqueado
);

  logic [N_BTN-1:0] bloqueo;

  // One independent channel per button.
  for (genvar i = 0; i < int'(N_BTN); i++) begin : g_canal
    canal_boton #(
      .DEB_CYC   (DEB_CYC),
      .REP_DELAY (REP_DELAY),
      .REP_RATE  (REP_RATE),
      .REP_EN    (REP_MASK[i])
    ) u_canal (
      .clk       (clk),
      .reset     (reset),
      .btn_n_i   (btn_n[i]),
      .pulso_o   (pulso[i]),
      .nivel_o   (nivel[i]),
      .bloqueo_o (bloqueo[i])
    );
  end

  assign bloqueado = |bloqueo;

endmodule

// File: tb/tb_acondicionador_botones.sv
// Scoreboard bench for acondicionador_botones (DEB_CYC=4, REP_DELAY=10, REP_RATE=5).
module tb_acondicionador_botones;
  import reloj_pkg::*;

  localparam int unsigned NB = 4;

  typedef struct {
    int         at;
    logic [3:0] val;
  } ev_t;

  // kind 0: nivel under mask, kind 1: bloqueado
  typedef struct {
    int         at;
    int         kind;
    logic [3:0] mask;
    logic [3:0] val;
  } st_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_n;
  logic [NB-1:0] pulso;
  logic [NB-1:0] nivel;
  logic          bloqueado;

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  bit  done = 1'b0;
  ev_t exp_q[$];
  st_t st_q[$];
  ev_t ev;
  st_t st;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  acondicionador_botones #(
    .N_BTN     (NB),
    .DEB_CYC   (4),
    .REP_DELAY (10),
    .REP_RATE  (5),
    .REP_MASK  (4'b0011)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_n     (btn_n),
    .pulso     (pulso),
    .nivel     (nivel),
    .bloqueado (bloqueado)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_pulse(input int at, input logic [3:0] v);
    exp_q.push_back('{at: at, val: v});
  endtask

  task automatic expect_st(input int kind, input logic [3:0] mask, input logic [3:0] v);
    st_q.push_back('{at: cyc, kind: kind, mask: mask, val: v});
  endtask

  // Monitor: compares pulses and status samples against the scoreboard.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
      ev = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL missed_pulse cycle=%0d got=none exp=%b", ev.at, ev.val);
    end
    if (pulso != 4'b0000) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse cycle=%0d got=%b exp=0000", cyc, pulso);
      end else begin
        ev = exp_q.pop_front();
        if (ev.at != cyc || ev.val != pulso) begin
          failures++;
          $display("FAIL pulse cycle=%0d got=%b exp=%b@%0d", cyc, pulso, ev.val, ev.at);
        end
      end
    end
    while (st_q.size() > 0 && st_q[0].at <= cyc) begin
      st = st_q.pop_front();
      checks++;
      if (st.kind == 0) begin
        if ((nivel & st.mask) != (st.val & st.mask)) begin
          failures++;
          $display("FAIL nivel cycle=%0d mask=%b got=%b exp=%b", cyc, st.mask,
                   nivel & st.mask, st.val & st.mask);
        end
      end else begin
        if (bloqueado != st.val[0]) begin
          failures++;
          $display("FAIL bloqueado cycle=%0d got=%b exp=%b", cyc, bloqueado, st.val[0]);
        end
      end
    end
    if (done) begin
      while (exp_q.size() > 0) begin
        ev = exp_q.pop_front();
        checks++;
        failures++;
        $display("FAIL missed_pulse cycle=%0d got=none exp=%b", ev.at, ev.val);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  // Stimulus: drives pins and posts expected pulses/levels.
  initial begin
    int c;
    reset = 1'b1;
    btn_n = 4'hF;

    // 1: reset, then lockout clears with all buttons released
    tick(3);
    expect_st(1, 4'h0, 4'h1);
    expect_st(0, 4'hF, 4'h0);
    reset = 1'b0;
    tick(3);
    expect_st(1, 4'h0, 4'h1);
    tick(7);
    expect_st(1, 4'h0, 4'h0);

    // 2: cambiar held, single pulse, no repeat
    c = cyc;
    btn_n[BTN_CAMB] = 1'b0;
    push_pulse(c + 7, 4'b0100);
    tick(30);
    expect_st(0, 4'b0100, 4'b0100);
    btn_n[BTN_CAMB] = 1'b1;
    tick(10);
    expect_st(0, 4'b0100, 4'b0000);

    // 3: incrementar held 40 cycles, auto-repeat
    c = cyc;
    btn_n[BTN_INCR] = 1'b0;
    push_pulse(c + 7,  4'b0001);
    push_pulse(c + 17, 4'b0001);
    push_pulse(c + 22, 4'b0001);
    push_pulse(c + 27, 4'b0001);
    push_pulse(c + 32, 4'b0001);
    push_pulse(c + 37, 4'b0001);
    push_pulse(c + 42, 4'b0001);
    tick(40);
    expect_st(0, 4'b0001, 4'b0001);
    btn_n[BTN_INCR] = 1'b1;
    tick(15);
    expect_st(0, 4'b0001, 4'b0000);

    // 4: decrementar glitch and bounce, filtered out
    btn_n[BTN_DECR] = 1'b0;
    tick(3);
    btn_n[BTN_DECR] = 1'b1;
    tick(4);
    expect_st(0, 4'b0010, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      btn_n[BTN_DECR] = 1'b0;
      tick(2);
      btn_n[BTN_DECR] = 1'b1;
      tick(2);
      expect_st(0, 4'b0010, 4'b0000);
    end
    tick(10);
    expect_st(0, 4'b0010, 4'b0000);

    // 5: simultaneous incr + establecer, release without pulse
    c = cyc;
    btn_n[BTN_INCR] = 1'b0;
    btn_n[BTN_EST]  = 1'b0;
    push_pulse(c + 7, 4'b1001);
    tick(10);
    btn_n[BTN_INCR] = 1'b1;
    btn_n[BTN_EST]  = 1'b1;
    tick(5);
    expect_st(0, 4'b1001, 4'b1001);
    tick(1);
    expect_st(0, 4'b1001, 4'b0000);
    tick(15);

    // 6: reset while incrementar held, lockout until released
    c = cyc;
    btn_n[BTN_INCR] = 1'b0;
    push_pulse(c + 7,  4'b0001);
    push_pulse(c + 17, 4'b0001);
    tick(19);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    expect_st(1, 4'h0, 4'h1);
    expect_st(0, 4'hF, 4'h0);
    for (int k = 0; k < 20; k++) begin
      tick(1);
      expect_st(1, 4'h0, 4'h1);
    end
    expect_st(0, 4'b0001, 4'b0001);
    btn_n[BTN_INCR] = 1'b1;
    tick(4);
    expect_st(1, 4'h0, 4'h1);
    tick(16);
    expect_st(1, 4'h0, 4'h0);
    expect_st(0, 4'b0001, 4'b0000);
    c = cyc;
    btn_n[BTN_INCR] = 1'b0;
    push_pulse(c + 7, 4'b0001);
    tick(8);
    btn_n[BTN_INCR] = 1'b1;
    tick(12);

    done = 1'b1;
  end

  // Watchdog: the run must always terminate.
  initial begin
    #200000;
    $display("FAIL timeout cycle=%0d got=running exp=finished", cyc);
    $fatal(1);
  end

endmodule
